hello_scroll_ctrl: RTL and testbench
====================================

HELLO_SCROLL_CTRL -- requirements
Module: hello_scroll_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, gives clock cycles per scroll step (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 SW  input  3  manual rotation index; legal values 0..5.
REQ-005 run  input  1  level; 1 = auto-scroll, 0 = manual.
REQ-006 pause  input  1  level; freezes auto-scroll while run=1.
REQ-007 dir  input  1  0 = advance (+1), 1 = retreat (-1).
REQ-008 step  input  1  level from pushbutton; rising edge detected internally; single-step while paused.
REQ-009 sel  output  3  registered rotation index, 0..5, fed to the six-position HELLO display mux select.
REQ-010 tick  output  1  one-cycle pulse coincident with each auto advance.
REQ-011 wrap  output  1  one-cycle pulse coincident with any sel change crossing 5->0 or 0->5.
REQ-012 mode  output  2  registered state: 00 MANUAL, 01 RUN, 10 PAUSE; 11 never driven.

Function
REQ-013 State machine SHALL have exactly three states: MANUAL, RUN, PAUSE.
REQ-014 MANUAL->RUN when run=1; RUN->PAUSE when run=1 and pause=1; PAUSE->RUN when run=1 and pause=0; any state->MANUAL when run=0.
REQ-015 run=0 SHALL take priority over all other inputs in the same cycle.
REQ-016 Prescaler: ceil(log2(TICK_DIV))-bit counter; in RUN increments each cycle, wraps TICK_DIV-1 -> 0.
REQ-017 In RUN, the edge where prescaler = TICK_DIV-1 SHALL update sel by +1 (dir=0) or -1 (dir=1) and register tick=1 for the following cycle only.
REQ-018 Prescaler SHALL hold its value in PAUSE and resume from that value on return to RUN.
REQ-019 Prescaler SHALL be cleared to 0 in MANUAL; first advance after entering RUN from MANUAL is exactly TICK_DIV cycles after mode reads 01.
REQ-020 sel arithmetic modulo 6: forward 5->0, backward 0->5; values 6,7 SHALL never appear on sel.
REQ-021 In MANUAL, sel SHALL load SW each cycle when SW<=5, and hold its previous value when SW is 6 or 7.
REQ-022 On MANUAL->RUN, sel SHALL keep its current value (no jump).
REQ-023 Step edge = step high this cycle, low previous cycle (one prior-value register).
REQ-024 In PAUSE, a step edge SHALL move sel one position per dir on the next edge and pulse wrap if crossing; tick stays 0.
REQ-025 Step edges SHALL be ignored in MANUAL and RUN; tick SHALL be 0 outside RUN.
REQ-026 dir is sampled on the advancing edge; changing dir mid-interval SHALL NOT reset the prescaler.
REQ-027 Same-cycle run falling and prescaler at TICK_DIV-1: no advance, no tick, state -> MANUAL.
REQ-028 Same-cycle pause rising and prescaler at TICK_DIV-1: no advance; prescaler holds TICK_DIV-1; advance occurs on first RUN cycle after unpause.

Reset
REQ-029 Reset=1 SHALL force, at the next edge: state MANUAL, mode=00, sel=0, prescaler=0, tick=0, wrap=0, step prior-value register=0.
REQ-030 Reset SHALL override all inputs and is honoured mid-interval, mid-pause and mid-step.
REQ-031 After Reset deasserts, the first cycle behaves per REQ-021 (MANUAL load of SW).

Verification (TICK_DIV overridden to 4)
REQ-032 Reset, SW=3, run=0 -> sel=3 one cycle later; SW=7 -> sel stays 3; mode=00.
REQ-033 From sel=3, run=1, dir=0 -> sel 4,5,0,1 at 4-cycle spacing; tick each advance; wrap only on 5->0.
REQ-034 RUN with sel=0, dir=1 -> next advance sel=5 with tick=1 and wrap=1 same cycle.
REQ-035 RUN, pause=1 at prescaler=2 for 10 cycles with step pulsed twice (dir=0) from sel=4 -> sel 5 then 0 (wrap=1 on second), tick=0; unpause -> next advance 2 cycles later.
REQ-036 run=0 on same cycle prescaler=3 -> no tick, sel unchanged, mode=00, prescaler=0.
REQ-037 Reset asserted in PAUSE with sel=4 -> next cycle sel=0, mode=00, tick=0, wrap=0.

Source files
------------

// File: rtl/hello_scroll_ctrl.sv
// Rotation-index controller for the six-position HELLO scroller: manual select,
// timed auto-scroll and single-step while paused, all modulo 6.
module hello_scroll_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [2:0] SW,
   input  logic       run,
   input  logic       pause,
   input  logic       dir,
   input  logic       step,
   output logic [2:0] sel,
   output logic       tick,
   output logic       wrap,
   output logic [1:0] mode
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [2:0]    SEL_MAX   = 3'd5;

   typedef enum logic [1:0] {
      MANUAL = 2'b00,
      RUN    = 2'b01,
      PAUSE  = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    sel_q, sel_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;
   logic          step_q;
   logic          step_edge;
   logic          move;

   assign step_edge = step & ~step_q;

   // NOTE: every variable written here gets a default first so no path can
   // leave it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      sel_d   = sel_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      move    = 1'b0;

      unique case (state_q)
         MANUAL: begin
            presc_d = '0;
            if (run)
               state_d = RUN;
            else if (SW <= SEL_MAX)
               sel_d = SW;
         end

         RUN: begin
            if (!run) begin
               state_d = MANUAL;
               presc_d = '0;
            end else if (pause) begin
               // Freezing on the terminal count leaves the advance pending for
               // the first cycle back in RUN.
               state_d = PAUSE;
            end else if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               move    = 1'b1;
               tick_d  = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end

         PAUSE: begin
            if (!run) begin
               state_d = MANUAL;
               presc_d = '0;
            end else begin
               if (!pause)
                  state_d = RUN;
               move = step_edge;
            end
         end

         default: begin
            state_d = MANUAL;
            presc_d = '0;
         end
      endcase

      // Rotations wrap modulo 6; manual SW loads are jumps, not rotations,
      // so they never raise wrap.
      if (move) begin
         if (dir) begin
            sel_d  = (sel_q == 3'd0) ? SEL_MAX : sel_q - 3'd1;
            wrap_d = (sel_q == 3'd0);
         end else begin
            sel_d  = (sel_q == SEL_MAX) ? 3'd0 : sel_q + 3'd1;
            wrap_d = (sel_q == SEL_MAX);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the pre-edge values, independent of statement order.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q <= MANUAL;
         presc_q <= '0;
         sel_q   <= 3'd0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         step_q  <= step;
      end
   end

   assign sel  = sel_q;
   assign tick = tick_q;
   assign wrap = wrap_q;
   assign mode = state_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Self-checking bench for hello_scroll_ctrl: directed scenarios followed by
// randomized levels, all compared against a modulo-6 reference model.
module tb_hello_scroll_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       Reset, run, pause, dir, step;
   logic [2:0] SW;
   logic [2:0] sel;
   logic       tick, wrap;
   logic [1:0] mode;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: mode 0 manual, 1 run, 2 pause; phase counts cycles
   // spent running since the last advance.
   int m_mode, m_sel, m_phase, m_tick, m_wrap, m_prev_step;

   hello_scroll_ctrl #(.TICK_DIV(TD)) dut (
      .CLOCK_50 (clk),
      .Reset    (Reset),
      .SW       (SW),
      .run      (run),
      .pause    (pause),
      .dir      (dir),
      .step     (step),
      .sel      (sel),
      .tick     (tick),
      .wrap     (wrap),
      .mode     (mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic rotate();
      int old_sel;
      old_sel = m_sel;
      m_sel   = dir ? (m_sel + 5) % 6 : (m_sel + 1) % 6;
      m_wrap  = ((old_sel == 5) && (m_sel == 0)) || ((old_sel == 0) && (m_sel == 5));
   endtask

   task automatic model_edge();
      bit step_rise;
      step_rise = step && !m_prev_step;
      m_tick = 0;
      m_wrap = 0;
      if (Reset) begin
         m_mode = 0; m_sel = 0; m_phase = 0; m_prev_step = 0;
         return;
      end
      m_prev_step = step;
      if (!run) begin
         if (m_mode == 0 && SW <= 5) m_sel = int'(SW);
         m_mode  = 0;
         m_phase = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (pause) m_mode = 2;
         else begin
            m_phase = (m_phase + 1) % TD;
            if (m_phase == 0) begin
               rotate();
               m_tick = 1;
            end
         end
      end else begin
         if (step_rise) rotate();
         if (!pause) m_mode = 1;
      end
   endtask

   // One clock: model follows the edge, outputs are compared 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("sel",  int'(sel),  m_sel);
      check("mode", int'(mode), m_mode);
      check("tick", int'(tick), m_tick);
      check("wrap", int'(wrap), m_wrap);
   endtask

   initial begin
      Reset = 1'b1; run = 1'b0; pause = 1'b0; dir = 1'b0; step = 1'b0; SW = 3'd0;
      m_mode = 0; m_sel = 0; m_phase = 0; m_tick = 0; m_wrap = 0; m_prev_step = 0;
      repeat (2) cycle();
      check("rst_sel", int'(sel), 0);
      check("rst_mode", int'(mode), 0);

      // Manual load and out-of-range hold
      Reset = 1'b0; SW = 3'd3;
      cycle();
      check("man_load", int'(sel), 3);
      SW = 3'd7;
      cycle();
      check("man_hold7", int'(sel), 3);
      check("man_mode", int'(mode), 0);

      // Forward auto-scroll 3 -> 4,5,0,1 at TD spacing
      run = 1'b1;
      cycle();
      check("run_entry_mode", int'(mode), 1);
      check("run_entry_sel", int'(sel), 3);
      repeat (TD - 1) cycle();
      check("adv1_early", int'(sel), 3);
      cycle();
      check("adv1_sel", int'(sel), 4);
      check("adv1_tick", int'(tick), 1);
      repeat (TD) cycle();
      check("adv2_sel", int'(sel), 5);
      repeat (TD) cycle();
      check("adv3_sel", int'(sel), 0);
      check("adv3_wrap", int'(wrap), 1);
      repeat (TD) cycle();
      check("adv4_sel", int'(sel), 1);
      check("adv4_wrap", int'(wrap), 0);

      // Backward through 0 -> 5
      dir = 1'b1;
      repeat (TD) cycle();
      check("back1_sel", int'(sel), 0);
      repeat (TD) cycle();
      check("back_wrap_sel", int'(sel), 5);
      check("back_wrap_tick", int'(tick), 1);
      check("back_wrap_wrap", int'(wrap), 1);
      repeat (TD) cycle();
      check("back2_sel", int'(sel), 4);

      // Pause at prescaler 2, two single steps, then resume
      dir = 1'b0;
      repeat (2) cycle();
      pause = 1'b1;
      cycle();
      check("pause_mode", int'(mode), 2);
      step = 1'b1; cycle();
      check("step1_sel", int'(sel), 5);
      check("step1_tick", int'(tick), 0);
      step = 1'b0; cycle();
      step = 1'b1; cycle();
      check("step2_sel", int'(sel), 0);
      check("step2_wrap", int'(wrap), 1);
      step = 1'b0;
      repeat (6) cycle();
      pause = 1'b0;
      cycle();
      check("resume_mode", int'(mode), 1);
      cycle();
      check("resume_early", int'(sel), 0);
      cycle();
      check("resume_adv", int'(sel), 1);
      check("resume_tick", int'(tick), 1);

      // run drop on terminal count: no advance, prescaler cleared
      repeat (TD - 1) cycle();
      run = 1'b0;
      cycle();
      check("drop_tick", int'(tick), 0);
      check("drop_sel", int'(sel), 1);
      check("drop_mode", int'(mode), 0);
      run = 1'b1;
      cycle();
      repeat (TD - 1) cycle();
      check("rerun_early", int'(sel), 1);
      cycle();
      check("rerun_adv", int'(sel), 2);

      // pause on terminal count: advance deferred to first RUN cycle
      repeat (TD - 1) cycle();
      pause = 1'b1;
      cycle();
      check("pause_tc_tick", int'(tick), 0);
      check("pause_tc_sel", int'(sel), 2);
      pause = 1'b0;
      cycle();
      cycle();
      check("unpause_adv", int'(sel), 3);
      check("unpause_tick", int'(tick), 1);

      // Reset while paused at sel 4
      pause = 1'b1;
      cycle();
      step = 1'b1; cycle();
      check("pre_rst_sel", int'(sel), 4);
      Reset = 1'b1;
      cycle();
      check("rst_pause_sel", int'(sel), 0);
      check("rst_pause_mode", int'(mode), 0);
      check("rst_pause_tick", int'(tick), 0);
      check("rst_pause_wrap", int'(wrap), 0);
      Reset = 1'b0; step = 1'b0; pause = 1'b0; run = 1'b0;

      // Randomized levels with occasional mid-activity resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0)  run   = ~run;
         if ($urandom_range(0, 14) == 0)  pause = ~pause;
         if ($urandom_range(0, 19) == 0)  dir   = ~dir;
         if ($urandom_range(0, 2) == 0)   step  = ~step;
         if ($urandom_range(0, 3) == 0)   SW    = 3'($urandom_range(0, 7));
         Reset = ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
